// File: rtl/membus_arbiter.sv
// DMA-to-CPU memory bus arbiter: steals the bus at microsequencer phase 0,
// runs bursts of 2-cycle transfers, then gives the CPU CPU_MIN boundaries back.
module membus_arbiter #(
  parameter int BURST_MAX = 16,
  parameter int CPU_MIN   = 1
) (
  input  logic        i_clk,
  input  logic        reset,
  input  logic [3:0]  uSval,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        dma_gnt,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic        cpu_hold,
  output logic        bus_addr_oe,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        mem_rd_n,
  output logic        mem_wr_n
);

  typedef enum logic [2:0] {IDLE, SYNC, ADDR, STRB, COOL} state_t;

  state_t      state, state_nxt;
  logic [7:0]  burst_cnt, burst_nxt;
  logic [3:0]  bnd_cnt, bnd_nxt;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q, rdata_q;
  logic        we_q;
  logic        latch;

  logic       boundary;
  logic [8:0] burst_inc;
  logic [4:0] bnd_inc;

  assign boundary  = (uSval == 4'd0);
  assign burst_inc = {1'b0, burst_cnt} + 9'd1;
  assign bnd_inc   = {1'b0, bnd_cnt} + 5'd1;

  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    bnd_nxt   = bnd_cnt;
    latch     = 1'b0;
    case (state)
      IDLE: if (dma_req) state_nxt = SYNC;
      SYNC: begin
        if (!dma_req) state_nxt = IDLE;
        else if (boundary) begin
          latch     = 1'b1;
          burst_nxt = 8'd0;
          state_nxt = ADDR;
        end
      end
      ADDR: state_nxt = STRB;
      STRB: begin
        if (burst_cnt != 8'hFF) burst_nxt = burst_inc[7:0];
        // burst_inc is the count including the transfer finishing now
        if (dma_req && (burst_inc < 9'(BURST_MAX))) begin
          latch     = 1'b1;
          state_nxt = ADDR;
        end else begin
          bnd_nxt   = 4'd0;
          state_nxt = COOL;
        end
      end
      COOL: begin
        if (boundary) begin
          if (bnd_inc >= 5'(CPU_MIN)) begin
            bnd_nxt   = 4'd0;
            state_nxt = IDLE;
          end else begin
            bnd_nxt = bnd_inc[3:0];
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      burst_cnt <= 8'd0;
      bnd_cnt   <= 4'd0;
      addr_q    <= 16'h0000;
      wdata_q   <= 8'h00;
      we_q      <= 1'b0;
      rdata_q   <= 8'h00;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      bnd_cnt   <= bnd_nxt;
      if (latch) begin
        addr_q  <= dma_addr;
        wdata_q <= dma_wdata;
        we_q    <= dma_we;
      end
      if (state == STRB && !we_q) rdata_q <= mem_rdata;
    end
  end

  // Outputs are also gated by reset so an abort never leaves a strobe low
  // while the state register is being cleared.
  logic in_xfer, strb;
  assign in_xfer = (state == ADDR) || (state == STRB);
  assign strb    = (state == STRB);

  assign dma_gnt     = reset & in_xfer;
  assign bus_addr_oe = reset & in_xfer;
  assign dma_ack     = reset & strb;
  assign cpu_hold    = reset & (in_xfer | ((state == SYNC) & boundary & dma_req));
  assign mem_rd_n    = ~(reset & strb & ~we_q);
  assign mem_wr_n    = ~(reset & strb & we_q);
  assign bus_addr    = addr_q;
  assign bus_wdata   = wdata_q;
  assign dma_rdata   = rdata_q;

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed vector table plus reset-abort and random invariant checks for membus_arbiter.
module tb_membus_arbiter;
  logic        i_clk = 1'b0;
  logic        reset;
  logic [3:0]  uSval;
  logic        dma_req, dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata, mem_rdata;
  logic        dma_gnt, dma_ack, cpu_hold, bus_addr_oe, mem_rd_n, mem_wr_n;
  logic [7:0]  dma_rdata, bus_wdata;
  logic [15:0] bus_addr;

  int compared = 0;
  int mismatched = 0;

  always #5 i_clk = ~i_clk;

  membus_arbiter #(.BURST_MAX(4), .CPU_MIN(2)) dut (
    .i_clk(i_clk), .reset(reset), .uSval(uSval), .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .mem_rdata(mem_rdata),
    .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_rdata(dma_rdata), .cpu_hold(cpu_hold),
    .bus_addr_oe(bus_addr_oe), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .mem_rd_n(mem_rd_n), .mem_wr_n(mem_wr_n)
  );

  // ctl = {gnt, ack, hold, addr_oe, rd_n, wr_n}
  typedef struct {
    logic [3:0]  us;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  mr;
    logic [5:0]  ctl;
    logic [7:0]  rdata;
    logic [15:0] baddr;
    logic [7:0]  bwd;
  } vec_t;

  vec_t vecs[$];

  localparam logic [5:0] C_IDLE = 6'b000011;
  localparam logic [5:0] C_HOLD = 6'b001011;
  localparam logic [5:0] C_ADDR = 6'b101111;
  localparam logic [5:0] C_RD   = 6'b111101;
  localparam logic [5:0] C_WR   = 6'b111110;
  localparam logic [37:0] RST_VAL = {C_IDLE, 8'h00, 16'h0000, 8'h00};

  function automatic logic [37:0] outs();
    return {dma_gnt, dma_ack, cpu_hold, bus_addr_oe, mem_rd_n, mem_wr_n,
            dma_rdata, bus_addr, bus_wdata};
  endfunction

  task automatic check(input string name, input logic [37:0] act, input logic [37:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] us, input logic req, input logic we,
                     input logic [15:0] addr, input logic [7:0] wd, input logic [7:0] mr,
                     input logic [5:0] ctl, input logic [7:0] rd, input logic [15:0] ba,
                     input logic [7:0] bw);
    vec_t v;
    v.us = us; v.req = req; v.we = we; v.addr = addr; v.wd = wd; v.mr = mr;
    v.ctl = ctl; v.rdata = rd; v.baddr = ba; v.bwd = bw;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [3:0] us, input logic req, input logic we,
                       input logic [15:0] addr, input logic [7:0] wd, input logic [7:0] mr);
    uSval = us; dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wd; mem_rdata = mr;
  endtask

  initial begin
    // early withdraw: request drops before any boundary is seen
    add(4'd5, 1, 0, 16'h0000, 8'h00, 8'h00, C_IDLE, 8'h00, 16'h0000, 8'h00);
    add(4'd5, 1, 0, 16'h0000, 8'h00, 8'h00, C_IDLE, 8'h00, 16'h0000, 8'h00);
    add(4'd0, 0, 0, 16'h0000, 8'h00, 8'h00, C_IDLE, 8'h00, 16'h0000, 8'h00);
    add(4'd0, 0, 0, 16'h0000, 8'h00, 8'h00, C_IDLE, 8'h00, 16'h0000, 8'h00);
    // single read, request dropped during ADDR
    add(4'd3, 1, 0, 16'h2040, 8'h00, 8'h00, C_IDLE, 8'h00, 16'h0000, 8'h00);
    add(4'd3, 1, 0, 16'h2040, 8'h00, 8'h00, C_IDLE, 8'h00, 16'h0000, 8'h00);
    add(4'd0, 1, 0, 16'h2040, 8'h00, 8'h00, C_HOLD, 8'h00, 16'h0000, 8'h00);
    add(4'd0, 0, 0, 16'h2040, 8'h00, 8'hA5, C_ADDR, 8'h00, 16'h2040, 8'h00);
    add(4'd0, 0, 0, 16'h2040, 8'h00, 8'hA5, C_RD,   8'h00, 16'h2040, 8'h00);
    // COOL: two boundaries needed, request ignored
    add(4'd0, 0, 0, 16'h0000, 8'h00, 8'h00, C_IDLE, 8'hA5, 16'h2040, 8'h00);
    add(4'd1, 1, 0, 16'h0000, 8'h00, 8'h00, C_IDLE, 8'hA5, 16'h2040, 8'h00);
    add(4'd0, 1, 0, 16'h0000, 8'h00, 8'h00, C_IDLE, 8'hA5, 16'h2040, 8'h00);
    // write burst 3000..3003, limited to 4 by BURST_MAX
    add(4'd0, 1, 1, 16'h3000, 8'h11, 8'h5A, C_IDLE, 8'hA5, 16'h2040, 8'h00);
    add(4'd0, 1, 1, 16'h3000, 8'h11, 8'h5A, C_HOLD, 8'hA5, 16'h2040, 8'h00);
    add(4'd0, 1, 1, 16'h3001, 8'h22, 8'h5A, C_ADDR, 8'hA5, 16'h3000, 8'h11);
    add(4'd0, 1, 1, 16'h3001, 8'h22, 8'h5A, C_WR,   8'hA5, 16'h3000, 8'h11);
    add(4'd0, 1, 1, 16'h3002, 8'h33, 8'h5A, C_ADDR, 8'hA5, 16'h3001, 8'h22);
    add(4'd0, 1, 1, 16'h3002, 8'h33, 8'h5A, C_WR,   8'hA5, 16'h3001, 8'h22);
    add(4'd0, 1, 1, 16'h3003, 8'h44, 8'h5A, C_ADDR, 8'hA5, 16'h3002, 8'h33);
    add(4'd0, 1, 1, 16'h3003, 8'h44, 8'h5A, C_WR,   8'hA5, 16'h3002, 8'h33);
    add(4'd0, 1, 1, 16'h3003, 8'h44, 8'h5A, C_ADDR, 8'hA5, 16'h3003, 8'h44);
    add(4'd0, 1, 1, 16'h3003, 8'h44, 8'h5A, C_WR,   8'hA5, 16'h3003, 8'h44);
    // held request must wait out the cool-down before a regrant
    add(4'd0, 1, 1, 16'h4000, 8'h55, 8'h5A, C_IDLE, 8'hA5, 16'h3003, 8'h44);
    add(4'd0, 1, 1, 16'h4000, 8'h55, 8'h5A, C_IDLE, 8'hA5, 16'h3003, 8'h44);
    add(4'd0, 1, 1, 16'h4000, 8'h55, 8'h5A, C_IDLE, 8'hA5, 16'h3003, 8'h44);
    add(4'd0, 1, 1, 16'h4000, 8'h55, 8'h5A, C_HOLD, 8'hA5, 16'h3003, 8'h44);
    add(4'd0, 1, 1, 16'h4000, 8'h55, 8'h5A, C_ADDR, 8'hA5, 16'h4000, 8'h55);

    reset = 1'b0;
    drive(4'd0, 0, 0, 16'h0000, 8'h00, 8'h00);
    #3 check("reset_values", outs(), RST_VAL);
    @(posedge i_clk);
    @(posedge i_clk);
    #1 reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].us, vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].mr);
      #2 check($sformatf("vec%0d", i), outs(),
               {vecs[i].ctl, vecs[i].rdata, vecs[i].baddr, vecs[i].bwd});
      @(posedge i_clk);
      #1;
    end

    // reset arrives in the middle of a write strobe
    #2 check("strb_before_reset", outs(), {C_WR, 8'hA5, 16'h4000, 8'h55});
    #1 reset = 1'b0;
    #1 check("async_reset_mid_strb", outs(), RST_VAL);
    @(posedge i_clk);
    #1 check("reset_held", outs(), RST_VAL);
    reset = 1'b1;

    for (int c = 0; c < 10000; c++) begin
      logic ok;
      drive(4'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            16'($urandom), 8'($urandom), 8'($urandom));
      #2;
      ok = 1'b1;
      if (!mem_rd_n && !mem_wr_n) ok = 1'b0;
      if ((!mem_rd_n || !mem_wr_n) && !dma_ack) ok = 1'b0;
      if (dma_ack && !dma_gnt) ok = 1'b0;
      if (dma_gnt && !(cpu_hold && bus_addr_oe)) ok = 1'b0;
      if (cpu_hold && !dma_gnt && !(uSval == 4'd0 && dma_req)) ok = 1'b0;
      compared++;
      if (!ok) begin
        mismatched++;
        if (mismatched < 20)
          $display("FAIL random_invariant cycle %0d: gnt=%b ack=%b hold=%b oe=%b rd_n=%b wr_n=%b uS=%0d req=%b",
                   c, dma_gnt, dma_ack, cpu_hold, bus_addr_oe, mem_rd_n, mem_wr_n, uSval, dma_req);
      end
      @(posedge i_clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
